// File: rtl/dbus_mem_responder_pkg.sv
// dbus_mem_responder_pkg: data-bus request/response types, responder FSM states and defaults
package dbus_mem_responder_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;
    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;
    localparam int DBUS_RESP_LATENCY_DEFAULT = 2;
endpackage

// File: rtl/dbus_mem_responder_if.sv
// dbus_mem_responder_if: core data-bus port bundle (request, response, range error)
interface dbus_mem_responder_if;
    import dbus_mem_responder_pkg::*;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    logic       err;
    modport master (output dreq, input dresp, err);
    modport slave (input dreq, output dresp, err);
endinterface

// File: rtl/dbus_mem_responder_sram.sv
// sram_bytewrite: 64-bit SRAM with byte-enable write and registered read, contents never reset
module sram_bytewrite #(
    parameter int DEPTH_WORDS = 4096
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [7:0]                     be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
    input  logic [63:0]                    wdata,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
    output logic [63:0]                    rdata
);
    logic [63:0] mem [DEPTH_WORDS];
    // byte-lane write and read-before-write registered read
    always_ff @(posedge clk) begin
        if (we) for (int i = 0; i < 8; i++) if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/dbus_mem_responder.sv
// dbus_mem_responder: fixed-latency data-bus responder backed by a byte-writable SRAM
module dbus_mem_responder
    import dbus_mem_responder_pkg::*;
#(
    parameter int          LATENCY     = DBUS_RESP_LATENCY_DEFAULT,
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
    input logic                 clk,
    input logic                 reset,
    dbus_mem_responder_if.slave bus
);
    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [63:0] SPAN     = 64'(DEPTH_WORDS) * 64'd8;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    resp_state_t   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [7:0]    strobe_q, strobe_d;
    logic [63:0]   data_q, data_d;
    logic          ok_q, ok_d;
    logic [63:0]   off;
    logic          in_range;
    logic [63:0]   rdata;
    logic          we;
    logic [AW-1:0] raddr;

    // offset from the SRAM base; the range check guards the index so nothing aliases
    always_comb begin
        off      = bus.dreq.addr - BASE_ADDR;
        in_range = (bus.dreq.addr >= BASE_ADDR) && (off < SPAN);
        we       = (state_q == RESP) && bus.dreq.valid && ok_q && (strobe_q != 8'h00);
        raddr    = (state_q == IDLE) ? off[AW+2:3] : idx_q;
    end

    // accept in IDLE, count down in WAIT, single response cycle; a dropped valid aborts
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        strobe_d = strobe_q;
        data_d   = data_q;
        ok_d     = ok_q;
        case (state_q)
            IDLE: if (bus.dreq.valid) begin
                state_d  = (LATENCY == 1) ? RESP : WAIT;
                cnt_d    = CNT_INIT;
                idx_d    = off[AW+2:3];
                strobe_d = bus.dreq.strobe;
                data_d   = bus.dreq.data;
                ok_d     = in_range;
            end
            WAIT: begin
                cnt_d   = bus.dreq.valid ? cnt_q - 4'd1 : 4'd0;
                state_d = !bus.dreq.valid ? IDLE : (cnt_q == 4'd1) ? RESP : WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    // state, counter and latched request registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            strobe_q <= '0;
            data_q   <= '0;
            ok_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            strobe_q <= strobe_d;
            data_q   <= data_d;
            ok_q     <= ok_d;
        end
    end

    // response comes only from flops, so it never depends on the request combinationally
    always_comb begin
        bus.dresp = '0;
        bus.err   = 1'b0;
        if (state_q == RESP) begin
            bus.dresp.addr_ok = 1'b1;
            bus.dresp.data_ok = 1'b1;
            bus.dresp.data    = ok_q ? rdata : 64'd0;
            bus.err           = !ok_q;
        end
    end

    sram_bytewrite #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
        .clk  (clk),
        .we   (we),
        .be   (strobe_q),
        .waddr(idx_q),
        .wdata(data_q),
        .raddr(raddr),
        .rdata(rdata)
    );
endmodule

// File: tb/tb_dbus_mem_responder.sv
// tb_dbus_mem_responder: directed checks of four responders with latencies 1..4 on a shared request
module tb_dbus_mem_responder;
    import dbus_mem_responder_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  req;
    dbus_resp_t resp [4];
    logic       err_v [4];
    int         n_checks = 0;
    int         n_fail = 0;

    dbus_mem_responder_if if_l1();
    dbus_mem_responder_if if_l2();
    dbus_mem_responder_if if_l3();
    dbus_mem_responder_if if_l4();

    assign if_l1.dreq = req;
    assign if_l2.dreq = req;
    assign if_l3.dreq = req;
    assign if_l4.dreq = req;
    assign resp[0] = if_l1.dresp;
    assign resp[1] = if_l2.dresp;
    assign resp[2] = if_l3.dresp;
    assign resp[3] = if_l4.dresp;
    assign err_v[0] = if_l1.err;
    assign err_v[1] = if_l2.err;
    assign err_v[2] = if_l3.err;
    assign err_v[3] = if_l4.err;

    dbus_mem_responder #(.LATENCY(1)) dut_l1 (.clk(clk), .reset(reset), .bus(if_l1));
    dbus_mem_responder #(.LATENCY(2)) dut_l2 (.clk(clk), .reset(reset), .bus(if_l2));
    dbus_mem_responder #(.LATENCY(3)) dut_l3 (.clk(clk), .reset(reset), .bus(if_l3));
    dbus_mem_responder #(.LATENCY(4)) dut_l4 (.clk(clk), .reset(reset), .bus(if_l4));

    always #5 clk = ~clk;

    // Issue a request at the current cycle, hold it through the response cycle, drop it after.
    // lat = cycles from acceptance to data_ok (0 if none within the budget).
    task automatic do_txn(input int sel, input logic [63:0] addr, input logic [7:0] strobe,
                          input logic [63:0] data, output logic [63:0] rd, output logic er,
                          output int lat, output logic ok_after);
        req = '{valid: 1'b1, addr: addr, size: 3'd3, strobe: strobe, data: data};
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (resp[sel].data_ok) begin
                lat = i;
                rd  = resp[sel].data;
                er  = err_v[sel];
            end
        end
        @(posedge clk); #1;
        req.valid = 1'b0;
        ok_after  = resp[sel].data_ok;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (resp[k] !== '0 || err_v[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_out[%0d]: got resp=%h err=%b expected 0", k, resp[k], err_v[k]);
            end
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [63:0] rd; logic er; int lat; logic oa;
        do_txn(1, 64'h8000_0010, 8'hFF, 64'h1122334455667788, rd, er, lat, oa);
        n_checks++;
        if (lat != 2 || er !== 1'b0 || oa !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_timing: got lat=%0d err=%b ok_after=%b expected lat=2 err=0 ok_after=0", lat, er, oa);
        end
        do_txn(1, 64'h8000_0010, 8'h00, 64'h0, rd, er, lat, oa);
        n_checks++;
        if (rd !== 64'h1122334455667788 || lat != 2 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_back: got data=%h lat=%0d err=%b expected 1122334455667788 lat=2 err=0", rd, lat, er);
        end
    endtask

    task automatic test_partial_write();
        logic [63:0] rd; logic er; int lat; logic oa;
        do_txn(1, 64'h8000_0010, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, rd, er, lat, oa);
        do_txn(1, 64'h8000_0010, 8'h00, 64'h0, rd, er, lat, oa);
        n_checks++;
        if (rd !== 64'h11223344_BBBBBBBB) begin
            n_fail++;
            $display("FAIL partial_wr: got %h expected 11223344bbbbbbbb", rd);
        end
    endtask

    task automatic test_out_of_range();
        logic [63:0] rd; logic er; int lat; logic oa;
        do_txn(1, 64'h0000_1000, 8'h00, 64'h0, rd, er, lat, oa);
        n_checks++;
        if (rd !== 64'h0 || er !== 1'b1 || lat != 2) begin
            n_fail++;
            $display("FAIL oor_read: got data=%h err=%b lat=%0d expected 0 1 2", rd, er, lat);
        end
        do_txn(1, 64'h7FFF_FFF8, 8'h00, 64'h0, rd, er, lat, oa);
        n_checks++;
        if (er !== 1'b1 || rd !== 64'h0) begin
            n_fail++;
            $display("FAIL below_base: got err=%b data=%h expected err=1 data=0", er, rd);
        end
        do_txn(1, 64'h8000_0000, 8'hFF, 64'h0123456789ABCDEF, rd, er, lat, oa);
        do_txn(1, 64'h8000_8000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, rd, er, lat, oa);
        n_checks++;
        if (er !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_write_err: got %b expected 1", er);
        end
        do_txn(1, 64'h8000_0000, 8'h00, 64'h0, rd, er, lat, oa);
        n_checks++;
        if (rd !== 64'h0123456789ABCDEF) begin
            n_fail++;
            $display("FAIL oor_no_alias: got %h expected 0123456789abcdef", rd);
        end
        do_txn(1, 64'h8000_0010, 8'h00, 64'h0, rd, er, lat, oa);
        n_checks++;
        if (rd !== 64'h11223344_BBBBBBBB) begin
            n_fail++;
            $display("FAIL oor_other_word: got %h expected 11223344bbbbbbbb", rd);
        end
        do_txn(1, 64'h8000_7FF8, 8'hFF, 64'hFEEDFACE_0BADF00D, rd, er, lat, oa);
        n_checks++;
        if (er !== 1'b0) begin
            n_fail++;
            $display("FAIL last_word_err: got %b expected 0", er);
        end
        do_txn(1, 64'h8000_7FF8, 8'h00, 64'h0, rd, er, lat, oa);
        n_checks++;
        if (rd !== 64'hFEEDFACE_0BADF00D || er !== 1'b0) begin
            n_fail++;
            $display("FAIL last_word_rd: got %h err=%b expected feedface0badf00d err=0", rd, er);
        end
    endtask

    task automatic test_abort();
        logic [63:0] rd; logic er; int lat; logic oa; logic seen;
        do_txn(2, 64'h8000_0040, 8'hFF, 64'h5555_6666_7777_8888, rd, er, lat, oa);
        n_checks++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL l3_latency: got %0d expected 3", lat);
        end
        req = '{valid: 1'b1, addr: 64'h8000_0040, size: 3'd3, strobe: 8'hFF, data: 64'hDEAD_BEEF_DEAD_BEEF};
        @(posedge clk); #1;
        req.valid = 1'b0;
        seen = resp[2].data_ok;
        @(posedge clk); #1;
        seen = seen | resp[2].data_ok;
        do_txn(2, 64'h8000_0040, 8'h00, 64'h0, rd, er, lat, oa);
        n_checks++;
        if (seen !== 1'b0 || lat != 3) begin
            n_fail++;
            $display("FAIL abort_idle: got data_ok_seen=%b next_lat=%0d expected 0 and 3", seen, lat);
        end
        n_checks++;
        if (rd !== 64'h5555_6666_7777_8888) begin
            n_fail++;
            $display("FAIL abort_nowrite: got %h expected 5555666677778888", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd; logic er; int lat; logic oa; logic bad;
        do_txn(3, 64'h8000_0020, 8'hFF, 64'h0F0E0D0C0B0A0908, rd, er, lat, oa);
        req = '{valid: 1'b1, addr: 64'h8000_0020, size: 3'd3, strobe: 8'h00, data: 64'h0};
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        req.valid = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (resp[3] !== '0 || err_v[3] !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got nonzero response after reset, expected all zero");
        end
        do_txn(3, 64'h8000_0020, 8'h00, 64'h0, rd, er, lat, oa);
        n_checks++;
        if (rd !== 64'h0F0E0D0C0B0A0908 || lat != 4) begin
            n_fail++;
            $display("FAIL reset_keeps_mem: got data=%h lat=%0d expected 0f0e0d0c0b0a0908 lat=4", rd, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd; logic er; int lat; logic oa;
        do_txn(0, 64'h8000_0100, 8'hFF, 64'hA1A1_A1A1_0000_1111, rd, er, lat, oa);
        do_txn(0, 64'h8000_0108, 8'hFF, 64'hB2B2_B2B2_2222_3333, rd, er, lat, oa);
        n_checks++;
        if (lat != 1) begin
            n_fail++;
            $display("FAIL l1_latency: got %0d expected 1", lat);
        end
        req = '{valid: 1'b1, addr: 64'h8000_0100, size: 3'd3, strobe: 8'h00, data: 64'h0};
        @(posedge clk); #1;
        n_checks++;
        if (resp[0].data_ok !== 1'b1 || resp[0].data !== 64'hA1A1_A1A1_0000_1111) begin
            n_fail++;
            $display("FAIL b2b_first: got ok=%b data=%h expected 1 a1a1a1a100001111", resp[0].data_ok, resp[0].data);
        end
        @(posedge clk); #1;
        n_checks++;
        if (resp[0].data_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: got data_ok=%b expected 0", resp[0].data_ok);
        end
        req.addr = 64'h8000_0108;
        @(posedge clk); #1;
        n_checks++;
        if (resp[0].data_ok !== 1'b1 || resp[0].data !== 64'hB2B2_B2B2_2222_3333) begin
            n_fail++;
            $display("FAIL b2b_second: got ok=%b data=%h expected 1 b2b2b2b222223333", resp[0].data_ok, resp[0].data);
        end
        @(posedge clk); #1;
        req.valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_write();
        test_out_of_range();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
